// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// 640x480@60 VGA timing generator with a 1 bpp framebuffer read port.
// Two-stage pipeline: memory read + stage-1 flops, then registered RGB/sync outputs.
module rvc_asap_5pl_vga_ctrl #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned V_VISIBLE = 480,
    parameter logic [11:0] FG_COLOR  = 12'hFFF,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        clock,
    input  logic        rst,
    output logic [13:0] address_b,
    input  logic [31:0] q_b,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        h_sync,
    output logic        v_sync,
    output logic        sof
);

    localparam int unsigned CNT_W          = 10;
    localparam int unsigned ADDR_W         = 14;
    localparam int unsigned WORDS_PER_LINE = H_VISIBLE / 32;
    localparam int unsigned H_TOTAL        = H_VISIBLE + 160;
    localparam int unsigned H_SYNC_START   = H_VISIBLE + 16;
    localparam int unsigned H_SYNC_END     = H_VISIBLE + 111;
    localparam int unsigned V_TOTAL        = V_VISIBLE + 45;
    localparam int unsigned V_SYNC_START   = V_VISIBLE + 10;
    localparam int unsigned V_SYNC_END     = V_VISIBLE + 11;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             frame_start;

    logic [4:0]       bit_idx1;
    logic             visible1;
    logic             hsync1;
    logic             vsync1;
    logic             sof1;
    logic             pixel;

    // Raster position counters.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == CNT_W'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    // Decode of the current counter position; address feeds the synchronous RAM.
    always_comb begin
        visible     = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
        hsync_raw   = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt <= CNT_W'(H_SYNC_END)));
        vsync_raw   = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt <= CNT_W'(V_SYNC_END)));
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        address_b   = '0;
        if (visible) begin
            address_b = ADDR_W'(v_cnt) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(h_cnt[9:5]);
        end
    end

    // Stage 1: timing context travels alongside the 1-cycle memory read.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            bit_idx1 <= '0;
            visible1 <= 1'b0;
            hsync1   <= 1'b1;
            vsync1   <= 1'b1;
            sof1     <= 1'b0;
        end else begin
            bit_idx1 <= h_cnt[4:0];
            visible1 <= visible;
            hsync1   <= hsync_raw;
            vsync1   <= vsync_raw;
            sof1     <= frame_start;
        end
    end

    assign pixel = q_b[bit_idx1];

    // Stage 2: registered outputs; blanking never looks at q_b.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            {red, green, blue} <= 12'h000;
            h_sync             <= 1'b1;
            v_sync             <= 1'b1;
            sof                <= 1'b0;
        end else begin
            if (!visible1) begin
                {red, green, blue} <= 12'h000;
            end else if (pixel) begin
                {red, green, blue} <= FG_COLOR;
            end else begin
                {red, green, blue} <= BG_COLOR;
            end
            h_sync <= hsync1;
            v_sync <= vsync1;
            sof    <= sof1;
        end
    end

endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// Scoreboard bench for rvc_asap_5pl_vga_ctrl with a short frame (2 visible lines)
// so a whole frame, sync widths and a mid-frame reset fit in a short run.
module tb_rvc_asap_5pl_vga_ctrl;

    localparam int unsigned H_VIS = 640;
    localparam int unsigned V_VIS = 2;
    localparam int unsigned H_TOT = 800;
    localparam int unsigned V_TOT = V_VIS + 45;
    localparam int unsigned FRAME = H_TOT * V_TOT;
    localparam logic [11:0] FG    = 12'hFFF;
    localparam logic [11:0] BG    = 12'h000;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        sof;
    } out_t;

    localparam out_t RESET_OUT = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1, sof: 1'b0};

    logic        clock = 1'b0;
    logic        rst   = 1'b1;
    logic [13:0] address_b;
    logic [31:0] q_b   = '0;
    logic [3:0]  red, green, blue;
    logic        h_sync, v_sync, sof;

    int   mode = 1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   h, v, k, frame;
    out_t sb[$];

    int   hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1;
    int   sof_t0 = -1, sof_t1 = -1, sof_after_rst = -1;
    int   vs_low = 0, fg_cnt = 0;
    logic hs_prev = 1'b1;
    bit   after_rst = 1'b0;

    rvc_asap_5pl_vga_ctrl #(
        .H_VISIBLE (H_VIS),
        .V_VISIBLE (V_VIS),
        .FG_COLOR  (FG),
        .BG_COLOR  (BG)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .address_b (address_b),
        .q_b       (q_b),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .sof       (sof)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [13:0] a, input int m);
        case (m)
            0:       return 32'h0000_0001;
            1:       return 32'hFFFF_FFFF;
            default: return ({18'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    // Synchronous read port: data valid one cycle after the address.
    always @(posedge clock) q_b <= mem_word(address_b, mode);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d k=%0d)", tag, got, exp, h, v, k);
        end
    endtask

    function automatic logic [13:0] exp_addr();
        if (h < H_VIS && v < V_VIS) return 14'(v * 20 + h / 32);
        return 14'd0;
    endfunction

    function automatic out_t exp_out();
        out_t        o;
        logic [31:0] w;
        bit          vis;
        vis   = (h < H_VIS) && (v < V_VIS);
        w     = mem_word(exp_addr(), mode);
        o.rgb = !vis ? 12'h000 : (w[h % 32] ? FG : BG);
        o.hs  = !(h >= 656 && h <= 751);
        o.vs  = !(v >= V_VIS + 10 && v <= V_VIS + 11);
        o.sof = (h == 0) && (v == 0);
        return o;
    endfunction

    // Frame 0: all ones; frame 1 line 0: address hash; line 1: single-bit then all ones.
    function automatic int pick_mode();
        if (frame == 0) return 1;
        if (v == 0)     return 2;
        if (h < 200)    return 0;
        return 1;
    endfunction

    task automatic restart_refs();
        h = 0; v = 0; k = 0;
        sb.delete();
        sb.push_back(RESET_OUT);
        sb.push_back(RESET_OUT);
    endtask

    task automatic step_cycle();
        out_t e;
        mode = pick_mode();
        check("address_b", 32'(address_b), 32'(exp_addr()));
        sb.push_back(exp_out());
        e = sb.pop_front();
        check("outputs", 32'({red, green, blue, h_sync, v_sync, sof}), 32'(e));

        if (!after_rst) begin
            if (hs_prev && !h_sync) begin
                if (hs_fall0 < 0)      hs_fall0 = k;
                else if (hs_fall1 < 0) hs_fall1 = k;
            end
            if (!hs_prev && h_sync && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = k;
            if (sof) begin
                if (sof_t0 < 0)      sof_t0 = k;
                else if (sof_t1 < 0) sof_t1 = k;
            end
            if (k < FRAME && !v_sync) vs_low++;
            if (k >= 2 && k < FRAME + 2 && {red, green, blue} == FG) fg_cnt++;
        end else if (sof && sof_after_rst < 0) begin
            sof_after_rst = k;
        end
        hs_prev = h_sync;

        @(negedge clock);
        k++;
        h++;
        if (h == H_TOT) begin
            h = 0;
            v++;
            if (v == V_TOT) begin
                v = 0;
                frame++;
            end
        end
    endtask

    initial begin
        h = 0; v = 0; k = 0; frame = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rgb", 32'({red, green, blue}), 32'h000);
        check("rst_sync", 32'({h_sync, v_sync}), 32'b11);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_addr", 32'(address_b), 32'd0);

        @(negedge clock);
        rst = 1'b0;
        restart_refs();
        while (!(frame == 1 && v == 1 && h == 300) && k < 45000 && n_errors <= 20) step_cycle();
        check("reached_reset_point", 32'(frame == 1 && v == 1 && h == 300), 32'd1);

        // Mid-line reset: outputs must drop before any clock edge.
        check("pre_rst_rgb", 32'({red, green, blue}), 32'(FG));
        rst = 1'b1;
        #1;
        check("async_rgb", 32'({red, green, blue}), 32'h000);
        check("async_sync", 32'({h_sync, v_sync}), 32'b11);
        check("async_sof", 32'(sof), 32'd0);
        check("async_addr", 32'(address_b), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        after_rst = 1'b1;
        frame = 1;
        restart_refs();
        repeat (40) if (n_errors <= 20) step_cycle();

        check("hs_first_low", 32'(hs_fall0), 32'd658);
        check("hs_low_width", 32'(hs_rise0 - hs_fall0), 32'd96);
        check("hs_period", 32'(hs_fall1 - hs_fall0), 32'd800);
        check("vs_low_cycles", 32'(vs_low), 32'd1600);
        check("sof_first", 32'(sof_t0), 32'd2);
        check("sof_period", 32'(sof_t1 - sof_t0), 32'(FRAME));
        check("fg_pixels", 32'(fg_cnt), 32'(H_VIS * V_VIS));
        check("sof_after_rst", 32'(sof_after_rst), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rvc_asap_5pl_vga_ctrl.md
RVC_ASAP_5PL_VGA_CTRL -- requirements
Module: rvc_asap_5pl_vga_ctrl

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter V_VISIBLE, 480, active lines per frame.
REQ-003 SHALL have parameter FG_COLOR, 12'hFFF, RGB444 colour for pixel bit = 1.
REQ-004 SHALL have parameter BG_COLOR, 12'h000, RGB444 colour for pixel bit = 0.
REQ-005 SHALL have port clock  in  1  single clock, 25 MHz pixel clock, all flops rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port address_b  out  14  word address into VGA memory read port.
REQ-008 SHALL have port q_b  in  32  VGA memory read data, valid 1 cycle after address_b.
REQ-009 SHALL have port red  out  4  red channel.
REQ-010 SHALL have port green  out  4  green channel.
REQ-011 SHALL have port blue  out  4  blue channel.
REQ-012 SHALL have port h_sync  out  1  horizontal sync, active low.
REQ-013 SHALL have port v_sync  out  1  vertical sync, active low.
REQ-014 SHALL have port sof  out  1  start-of-frame pulse, 1 cycle high.

Function
REQ-015 SHALL keep h_cnt (10b) counting 0..799 per clock, wrapping 799->0.
REQ-016 SHALL keep v_cnt (10b) incrementing only when h_cnt wraps, counting 0..524, wrapping 524->0.
REQ-017 SHALL define visible = (h_cnt < 640) and (v_cnt < 480).
REQ-018 SHALL define raw hsync low for h_cnt 656..751 inclusive (FP 640..655, BP 752..799).
REQ-019 SHALL define raw vsync low for v_cnt 490..491 inclusive (FP 480..489, BP 492..524).
REQ-020 SHALL drive address_b combinationally = v_cnt*20 + h_cnt[9:5] when visible, else 14'd0; max value 9599, computed without truncation within 14 bits.
REQ-021 SHALL treat memory as 1 bpp: word at address holds 32 horizontal pixels, bit 0 = leftmost (h_cnt[4:0]=0).
REQ-022 SHALL pipeline stage 1: register h_cnt[4:0], visible, raw hsync, raw vsync alongside the memory's 1-cycle read.
REQ-023 SHALL pipeline stage 2: register outputs; pixel = q_b[stage1 bit index]; {red,green,blue} = FG_COLOR if visible1 and pixel=1, BG_COLOR if visible1 and pixel=0, 12'h000 if not visible1.
REQ-024 SHALL give total latency of exactly 2 clocks from counter value to red/green/blue/h_sync/v_sync; all five outputs mutually aligned.
REQ-025 SHALL assert sof for one cycle aligned with output of pixel (0,0), i.e. 2 clocks after h_cnt=0,v_cnt=0.
REQ-026 SHALL blank RGB to 12'h000 during every non-visible cycle regardless of q_b.
REQ-027 SHALL not depend on q_b contents for sync timing; sync outputs toggle even with q_b = X.

Reset
REQ-028 SHALL, while rst=1, force h_cnt=0, v_cnt=0, all pipeline flops to inactive: red/green/blue=0, h_sync=1, v_sync=1, sof=0.
REQ-029 SHALL, on rst deassertion, start at pixel (0,0) with address_b=0 on the first cycle; first sof 2 cycles after first active clock edge.
REQ-030 SHALL, on rst assertion mid-frame, immediately (asynchronously) return all outputs to reset values and restart the frame from (0,0) after release.

Verification
REQ-031 SHALL cover: release reset -> address_b=0, then 0 for h 0..31, 1 for h 32..63, ..., 19 for h 608..639, 0 for h 640..799; line 1 starts at 20; line 479 last word 9599.
REQ-032 SHALL cover: free run one line -> h_sync low exactly 96 clocks, first low output 658 clocks after reset release; period 800 clocks.
REQ-033 SHALL cover: free run one frame -> v_sync low exactly 1600 clocks (2 lines); frame period 420000 clocks; sof period 420000.
REQ-034 SHALL cover: memory model returns 32'h0000_0001 for all words -> RGB=12'hFFF at output pixel x%32==0 only within visible area, 12'h000 elsewhere, including blanking.
REQ-035 SHALL cover: q_b forced 32'hFFFF_FFFF -> RGB=FG_COLOR for exactly 640x480 pixels per frame, 0 during blanking.
REQ-036 SHALL cover: rst pulsed at h=300,v=200 -> outputs reset within same cycle (h_sync=1,v_sync=1,RGB=0), after release counting restarts at (0,0) and sof recurs 2 clocks later.
